// File: rtl/i2c_codec_slave.sv
// ---------------------------------------------------------------------------
// i2c_codec_slave
//
// I2C target that stands in for the audio codec on the configuration bus.
// It accepts 3-byte write frames: {SLAVE_ADDR, W}, {reg[6:0], data[8]},
// data[7:0]. Each completed write pulses wr_strobe and updates a 9-bit-wide
// register file of 2**REG_AW entries. A write to RESET_REG clears the file.
//
// Ports:
//   CLOCK_50   in     system clock, everything is synchronous to it
//   reset      in     synchronous active-high reset
//   I2C_SCLK   in     bus clock from the master
//   I2C_SDAT   inout  open-drain data, driven only to 0 or Z
//   wr_strobe  out    one-cycle pulse per completed register write
//   wr_addr    out    [6:0] register address of the last write
//   wr_data    out    [8:0] data of the last write
//   rd_addr    in     [REG_AW-1:0] register file read index
//   rd_data    out    [8:0] register file contents at rd_addr (combinational)
//   busy       out    high from the address ACK until STOP
//
// Optional feature, macro I2C_CODEC_SLAVE_READ_EN:
//   Address {SLAVE_ADDR, R} is ACKed and the block returns two bytes,
//   {last reg, entry[8]} then entry[7:0], repeating while the master ACKs.
//   Without the macro read addresses are NACKed and no transmit logic exists.
//
// Handshake: there is no valid/ready pair; wr_strobe is a single-cycle
// qualifier for wr_addr/wr_data, which hold their value until the next write.
// The FSM state is held in state_q for observation.
// ---------------------------------------------------------------------------
module i2c_codec_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h1A,
    parameter int         REG_AW     = 4,
    parameter logic [6:0] RESET_REG  = 7'h0F
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              I2C_SCLK,
    inout  wire               I2C_SDAT,
    output logic              wr_strobe,
    output logic [6:0]        wr_addr,
    output logic [8:0]        wr_data,
    input  logic [REG_AW-1:0] rd_addr,
    output logic [8:0]        rd_data,
    output logic              busy
);

    localparam int DEPTH = 1 << REG_AW;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_BYTE1    = 4'd3,
        ST_ACK1     = 4'd4,
        ST_BYTE2    = 4'd5,
        ST_ACK2     = 4'd6,
        ST_IGNORE   = 4'd7
`ifdef I2C_CODEC_SLAVE_READ_EN
        ,
        ST_TX       = 4'd8,
        ST_TX_ACK   = 4'd9
`endif
    } state_t;

    state_t state_q, state_d;

    // Synchronizer (meta, sync) plus one history flop per bus line.
    logic scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d, scl_hist_q, scl_hist_d;
    logic sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d, sda_hist_q, sda_hist_d;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       ack_phase_q, ack_phase_d;   // 1 while the ACK low is on the bus
    logic       sda_oe_q, sda_oe_d;
    logic [6:0] reg_addr_q, reg_addr_d;
    logic       d8_q, d8_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [8:0] wr_data_q, wr_data_d;
    logic       busy_q, busy_d;
    logic [8:0] regs_q [DEPTH];
    logic [8:0] regs_d [DEPTH];

    logic       scl_rise, scl_fall, start_det, stop_det, sda_in;
    logic       last_bit, addr_wr_match, addr_ok, reg_in_range;
    logic [7:0] addr_byte;
    logic [8:0] byte_data;

`ifdef I2C_CODEC_SLAVE_READ_EN
    logic       rd_mode_q, rd_mode_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       tx_second_q, tx_second_d;   // 1 once the data byte of the pair is loaded
    logic       addr_rd_match;
    logic [8:0] tx_entry;
    logic [7:0] tx_byte1, tx_byte2;
`endif

    always_comb begin
        scl_meta_d = I2C_SCLK;
        scl_sync_d = scl_meta_q;
        scl_hist_d = scl_sync_q;
        sda_meta_d = I2C_SDAT;
        sda_sync_d = sda_meta_q;
        sda_hist_d = sda_sync_q;
    end

    // START/STOP need SCL high in both the current and previous sample so an
    // SDA change that straddles an SCL edge is not mistaken for a condition.
    always_comb begin
        sda_in        = sda_sync_q;
        scl_rise      = scl_sync_q & ~scl_hist_q;
        scl_fall      = ~scl_sync_q & scl_hist_q;
        start_det     = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
        stop_det      = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
        last_bit      = (bit_cnt_q == 3'd7);
        addr_byte     = {shift_q, sda_in};
        addr_wr_match = (addr_byte == {SLAVE_ADDR, 1'b0});
        byte_data     = {d8_q, shift_q, sda_in};
        reg_in_range  = (32'(reg_addr_q) < 32'(DEPTH));
`ifdef I2C_CODEC_SLAVE_READ_EN
        addr_rd_match = (addr_byte == {SLAVE_ADDR, 1'b1});
        addr_ok       = addr_wr_match | addr_rd_match;
        tx_entry      = reg_in_range ? regs_q[reg_addr_q[REG_AW-1:0]] : 9'd0;
        tx_byte1      = {reg_addr_q, tx_entry[8]};
        tx_byte2      = tx_entry[7:0];
`else
        addr_ok       = addr_wr_match;
`endif
    end

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; bus conditions win over any simultaneous SCL edge.
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = ST_ADDR;
        end else if (stop_det) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_ADDR:     if (scl_rise && last_bit) state_d = addr_ok ? ST_ADDR_ACK : ST_IGNORE;
                ST_BYTE1:    if (scl_rise && last_bit) state_d = ST_ACK1;
                ST_BYTE2:    if (scl_rise && last_bit) state_d = ST_ACK2;
                ST_ADDR_ACK: begin
                    if (scl_fall && ack_phase_q) begin
`ifdef I2C_CODEC_SLAVE_READ_EN
                        state_d = rd_mode_q ? ST_TX : ST_BYTE1;
`else
                        state_d = ST_BYTE1;
`endif
                    end
                end
                ST_ACK1:     if (scl_fall && ack_phase_q) state_d = ST_BYTE2;
                ST_ACK2:     if (scl_fall && ack_phase_q) state_d = ST_IGNORE;
`ifdef I2C_CODEC_SLAVE_READ_EN
                ST_TX:       if (scl_fall && last_bit) state_d = ST_TX_ACK;
                ST_TX_ACK: begin
                    if (scl_rise && sda_in) state_d = ST_IGNORE;   // master NACK
                    else if (scl_fall)      state_d = ST_TX;
                end
`endif
                default:     state_d = state_q;
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ack_phase_d = ack_phase_q;
        sda_oe_d    = sda_oe_q;
        reg_addr_d  = reg_addr_q;
        d8_d        = d8_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        busy_d      = busy_q;
        regs_d      = regs_q;
`ifdef I2C_CODEC_SLAVE_READ_EN
        rd_mode_d   = rd_mode_q;
        tx_shift_d  = tx_shift_q;
        tx_second_d = tx_second_q;
`endif
        if (start_det || stop_det) begin
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
            sda_oe_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_BYTE1, ST_BYTE2: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda_in};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            if (state_q == ST_ADDR) begin
                                if (addr_ok) busy_d = 1'b1;
`ifdef I2C_CODEC_SLAVE_READ_EN
                                rd_mode_d = addr_rd_match;
`endif
                            end else if (state_q == ST_BYTE1) begin
                                reg_addr_d = shift_q;
                                d8_d       = sda_in;
                            end else begin
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = reg_addr_q;
                                wr_data_d   = byte_data;
                                // The clear overrides the normal write; out-of-range
                                // addresses still strobe but leave the file alone.
                                if (reg_addr_q == RESET_REG) begin
                                    for (int i = 0; i < DEPTH; i++) regs_d[i] = 9'd0;
                                end else if (reg_in_range) begin
                                    regs_d[reg_addr_q[REG_AW-1:0]] = byte_data;
                                end
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_ACK1, ST_ACK2: begin
                    // First fall after the 8th bit pulls SDA low, the next releases it.
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            ack_phase_d = 1'b1;
                            sda_oe_d    = 1'b1;
                        end else begin
                            ack_phase_d = 1'b0;
                            sda_oe_d    = 1'b0;
                            bit_cnt_d   = 3'd0;
`ifdef I2C_CODEC_SLAVE_READ_EN
                            if (state_q == ST_ADDR_ACK && rd_mode_q) begin
                                tx_shift_d  = tx_byte1;
                                tx_second_d = 1'b0;
                                sda_oe_d    = ~tx_byte1[7];
                            end
`endif
                        end
                    end
                end
`ifdef I2C_CODEC_SLAVE_READ_EN
                ST_TX: begin
                    if (scl_fall) begin
                        if (last_bit) begin
                            sda_oe_d  = 1'b0;   // hand SDA to the master for its ACK
                            bit_cnt_d = 3'd0;
                        end else begin
                            bit_cnt_d  = bit_cnt_q + 3'd1;
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                            sda_oe_d   = ~tx_shift_q[6];
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_fall && !(scl_rise && sda_in)) begin
                        tx_second_d = ~tx_second_q;
                        tx_shift_d  = tx_second_q ? tx_byte1 : tx_byte2;
                        sda_oe_d    = tx_second_q ? ~tx_byte1[7] : ~tx_byte2[7];
                    end
                end
`endif
                default: ;
            endcase
        end
        if (state_d == ST_IDLE) busy_d = 1'b0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            scl_meta_q  <= 1'b1;
            scl_sync_q  <= 1'b1;
            scl_hist_q  <= 1'b1;
            sda_meta_q  <= 1'b1;
            sda_sync_q  <= 1'b1;
            sda_hist_q  <= 1'b1;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            ack_phase_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= 7'd0;
            d8_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 7'd0;
            wr_data_q   <= 9'd0;
            busy_q      <= 1'b0;
            regs_q      <= '{default: '0};
`ifdef I2C_CODEC_SLAVE_READ_EN
            rd_mode_q   <= 1'b0;
            tx_shift_q  <= 8'd0;
            tx_second_q <= 1'b0;
`endif
        end else begin
            scl_meta_q  <= scl_meta_d;
            scl_sync_q  <= scl_sync_d;
            scl_hist_q  <= scl_hist_d;
            sda_meta_q  <= sda_meta_d;
            sda_sync_q  <= sda_sync_d;
            sda_hist_q  <= sda_hist_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ack_phase_q <= ack_phase_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            d8_q        <= d8_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            regs_q      <= regs_d;
`ifdef I2C_CODEC_SLAVE_READ_EN
            rd_mode_q   <= rd_mode_d;
            tx_shift_q  <= tx_shift_d;
            tx_second_q <= tx_second_d;
`endif
        end
    end

    assign I2C_SDAT  = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign rd_data   = regs_q[rd_addr];

endmodule

// File: tb/tb_i2c_codec_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_codec_slave
//
// Bus-level master model drives write (and optionally read) frames. A
// register-file model plus an expected-write queue predict wr_strobe,
// wr_addr, wr_data and rd_data; literal values pin the model.
// ---------------------------------------------------------------------------
module tb_i2c_codec_slave;

    localparam int Q = 8;   // CLOCK_50 cycles per quarter SCL period

    // ---------------- clock / reset / signals ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    wire        sda_bus;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [8:0]  m_regs [16];
    logic [15:0] exp_q [$];
    logic [15:0] exp_w;

    always #5 clk = ~clk;

    assign sda_bus = sda_m ? 1'bz : 1'b0;
    pullup (sda_bus);

    i2c_codec_slave dut (
        .CLOCK_50  (clk),
        .reset     (rst),
        .I2C_SCLK  (scl_m),
        .I2C_SDAT  (sda_bus),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Register-file model: a write to 0x0F clears everything, addresses 16
    // and above leave the file unchanged, every accepted frame strobes once.
    task automatic model_write(input logic [6:0] r, input logic [8:0] d);
        exp_q.push_back({r, d});
        if (r == 7'h0F) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 9'd0;
        end else if (r < 7'd16) begin
            m_regs[r[3:0]] = d;
        end
    endtask

    // Scoreboard: every strobe cycle must match the head of the queue.
    always @(negedge clk) begin
        if (wr_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL strobe_unexpected: got addr %0h data %0h, expected no strobe", wr_addr, wr_data);
            end else begin
                exp_w = exp_q.pop_front();
                check("strobe", {wr_addr, wr_data}, exp_w);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_start();
        if (!scl_m) begin
            sda_m = 1'b1;
            wait_clk(Q);
            scl_m = 1'b1;
            wait_clk(Q);
        end
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_stop();
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(Q);
    endtask

    task automatic send_bit(input logic b, output logic s);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        s = sda_bus;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(d[i], s);
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic master_nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(master_nack, s);
    endtask

    task automatic read_reg(input logic [3:0] r, output logic [8:0] v);
        @(negedge clk);
        rd_addr = r;
        #1;
        v = rd_data;
    endtask

    task automatic check_file(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd_addr = 4'(i);
            #1;
            check(tag, 16'(rd_data), 16'(m_regs[i]));
        end
    endtask

    task automatic write_frame(input logic [7:0] a, input logic [7:0] b1, input logic [7:0] b2,
                               input logic extra, input string tag);
        logic ack;
        logic addr_ok;
        addr_ok = (a == 8'h34);
        if (addr_ok) model_write(b1[7:1], {b1[0], b2});
        send_start();
        send_byte(a, ack);
        check({tag, "_ack_addr"}, 16'(ack), 16'(addr_ok));
        check({tag, "_busy"}, 16'(busy), 16'(addr_ok));
        send_byte(b1, ack);
        check({tag, "_ack1"}, 16'(ack), 16'(addr_ok));
        send_byte(b2, ack);
        check({tag, "_ack2"}, 16'(ack), 16'(addr_ok));
        if (extra) begin
            send_byte(8'hAA, ack);
            check({tag, "_ack_extra"}, 16'(ack), 16'd0);
        end
        send_stop();
        wait_clk(4);
        @(negedge clk);
        check({tag, "_busy_idle"}, 16'(busy), 16'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic       ack;
        logic       s;
        logic [7:0] b;
        logic [7:0] a34;
        logic [8:0] v;

        rst     = 1'b1;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        rd_addr = 4'd0;
        a34     = 8'h34;
        for (int i = 0; i < 16; i++) m_regs[i] = 9'd0;
        wait_clk(4);
        @(negedge clk);
        check("rst_strobe", 16'(wr_strobe), 16'd0);
        check("rst_addr", 16'(wr_addr), 16'd0);
        check("rst_data", 16'(wr_data), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_sda", 16'(sda_bus), 16'd1);
        rst = 1'b0;
        wait_clk(4);
        check_file("rst_file");

        // Basic write: reg 7 <= 9'h04D
        write_frame(8'h34, 8'h0E, 8'h4D, 1'b0, "w7");
        read_reg(4'd7, v);
        check("lit_reg7", 16'(v), 16'h004D);
        check_file("w7_file");

`ifdef I2C_CODEC_SLAVE_READ_EN
        send_start();
        send_byte(8'h35, ack);
        check("rd_ack_addr", 16'(ack), 16'd1);
        read_byte(1'b0, b);
        check("rd_byte1", 16'(b), 16'({7'd7, m_regs[7][8]}));
        check("lit_rd_byte1", 16'(b), 16'h000E);
        read_byte(1'b1, b);
        check("rd_byte2", 16'(b), 16'(m_regs[7][7:0]));
        check("lit_rd_byte2", 16'(b), 16'h004D);
        send_stop();
`else
        send_start();
        send_byte(8'h35, ack);
        check("rd_nack_addr", 16'(ack), 16'd0);
        send_byte(8'h0E, ack);
        check("rd_nack_byte", 16'(ack), 16'd0);
        send_stop();
`endif
        wait_clk(4);
        @(negedge clk);
        check("rd_busy_idle", 16'(busy), 16'd0);

        // Foreign address
        write_frame(8'h40, 8'h0E, 8'h99, 1'b0, "bad_addr");
        check_file("bad_addr_file");

        // Write reg 0, then clear through the reset register
        write_frame(8'h34, 8'h01, 8'h18, 1'b0, "w0");
        read_reg(4'd0, v);
        check("lit_reg0", 16'(v), 16'h0118);
        write_frame(8'h34, 8'h1E, 8'h00, 1'b0, "clr");
        check_file("clr_file");

        // Out-of-range register, then reg 14 with bit 8 set and a trailing byte
        write_frame(8'h34, 8'h40, 8'h12, 1'b0, "oor");
        write_frame(8'h34, 8'h1D, 8'hFF, 1'b1, "w14");
        read_reg(4'd14, v);
        check("lit_reg14", 16'(v), 16'h01FF);
        check_file("w14_file");

        // STOP after two bytes: frame discarded
        send_start();
        send_byte(8'h34, ack);
        check("part_ack_addr", 16'(ack), 16'd1);
        send_byte(8'h0A, ack);
        check("part_ack1", 16'(ack), 16'd1);
        send_stop();
        wait_clk(4);
        @(negedge clk);
        check("part_busy", 16'(busy), 16'd0);
        check_file("part_file");

        // Repeated START three bits into byte 1, then a full frame
        send_start();
        send_byte(8'h34, ack);
        send_bit(1'b0, s);
        send_bit(1'b0, s);
        send_bit(1'b1, s);
        write_frame(8'h34, 8'h0A, 8'h55, 1'b0, "rstart");
        read_reg(4'd5, v);
        check("lit_reg5", 16'(v), 16'h0055);

        // Reset pulse while the address ACK is on the bus
        send_start();
        for (int i = 7; i >= 0; i--) send_bit(a34[i], s);
        sda_m = 1'b1;
        wait_clk(Q);
        check("mid_ack_driven", 16'(sda_bus), 16'd0);
        check("mid_busy", 16'(busy), 16'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_sda", 16'(sda_bus), 16'd1);
        check("mid_rst_strobe", 16'(wr_strobe), 16'd0);
        check("mid_rst_busy", 16'(busy), 16'd0);
        check("mid_rst_addr", 16'(wr_addr), 16'd0);
        check("mid_rst_data", 16'(wr_data), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = 9'd0;
        send_stop();
        check_file("mid_rst_file");
        write_frame(8'h34, 8'h06, 8'h33, 1'b0, "after_rst");
        check_file("after_rst_file");

        wait_clk(8);
        check("strobes_all_seen", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
